frame_scanner: RTL and testbench

Synthesizable, parametrised frame readout engine. On a frame trigger it walks a PX_WIDTH x PX_HEIGHT pixel buffer in raster order through the renderer's second read port. It streams pixel codes out over a valid/ready interface with row and frame markers. It replaces the fixed-size, zero-latency, unthrottled frame dump loop, adding read latency, backpressure, frame decimation and overrun accounting.

---
 rtl/frame_scanner.sv | 148 ++++++++++++++
 tb/tb_frame_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scanner.sv
// Frame readout engine: walks the pixel buffer in raster order through a
// fixed-latency read port and streams pixels over valid/ready with eol/eof marks.
module frame_scanner #(
    parameter int PX_WIDTH  = 160,
    parameter int PX_HEIGHT = 120,
    parameter int PIX_BITS  = 3,
    parameter int ADDR_W    = 16,
    parameter int RD_LAT    = 1,
    parameter int DECIM     = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                frame_tick,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [PIX_BITS-1:0] rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PIX_BITS-1:0] out_data,
    output logic                out_eol,
    output logic                out_eof,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output logic [7:0]          drop_cnt
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int COL_W = (PX_WIDTH  > 1) ? $clog2(PX_WIDTH)  : 1;
    localparam int ROW_W = (PX_HEIGHT > 1) ? $clog2(PX_HEIGHT) : 1;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef struct packed {
        logic eol;
        logic eof;
    } mark_t;

    typedef struct packed {
        logic [PIX_BITS-1:0] data;
        logic                eol;
        logic                eof;
    } beat_t;

    logic [1:0]       state;
    logic [PH_W-1:0]  phase;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [RD_LAT:1]  vld_pipe;
    mark_t [RD_LAT:1] mark_pipe;
    beat_t            fifo [DEPTH];

    logic  last_col, last_px, push, pop;
    mark_t issue_mark;
    beat_t head;

    assign last_col   = (col == COL_W'(PX_WIDTH - 1));
    assign last_px    = last_col && (row == ROW_W'(PX_HEIGHT - 1));
    assign issue_mark = '{eol: last_col, eof: last_px};

    // A read is issued only if its return is guaranteed a FIFO slot.
    assign rd_en     = (state == SCAN) && (inflight < CNT_W'(DEPTH));
    assign busy      = (state != IDLE);
    assign push      = vld_pipe[RD_LAT];
    assign head      = fifo[rd_ptr];
    assign out_valid = (count != '0);
    assign out_data  = head.data;
    assign out_eol   = head.eol;
    assign out_eof   = head.eof;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= IDLE;
            phase     <= '0;
            col       <= '0;
            row       <= '0;
            rd_addr   <= '0;
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (frame_tick && busy && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;
                        if (phase == '0)
                            state <= SCAN;
                    end
                end
                SCAN: begin
                    if (rd_en) begin
                        // counters rewind on the last issue so the next frame starts at 0
                        rd_addr <= last_px ? '0 : rd_addr + 1'b1;
                        col     <= last_col ? '0 : col + 1'b1;
                        if (last_col)
                            row <= last_px ? '0 : row + 1'b1;
                        if (last_px)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head.eof) begin
                        state     <= IDLE;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            vld_pipe  <= '0;
            mark_pipe <= '0;
            inflight  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++)
                fifo[i] <= '0;
        end else begin
            vld_pipe[1]  <= rd_en;
            mark_pipe[1] <= issue_mark;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe[k]  <= vld_pipe[k-1];
                mark_pipe[k] <= mark_pipe[k-1];
            end
            if (push) begin
                fifo[wr_ptr] <= '{data: rd_data, eol: mark_pipe[RD_LAT].eol,
                                  eof: mark_pipe[RD_LAT].eof};
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            inflight <= inflight + CNT_W'(rd_en) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: 4x3 frame, 2-cycle read latency, every 3rd trigger scanned.
module tb_frame_scanner;
    localparam int W = 4, H = 3, LAT = 2, DEC = 3, N = W * H, DEPTH = LAT + 2;

    typedef struct packed {
        logic [2:0] d;
        logic       eol;
        logic       eof;
    } beat_t;

    logic        clk = 1'b0, clr = 1'b0, frame_tick = 1'b0, out_ready = 1'b0;
    logic        rd_en, out_valid, out_eol, out_eof, busy;
    logic [15:0] rd_addr, frame_cnt;
    logic [2:0]  rd_data, out_data;
    logic [7:0]  drop_cnt;

    frame_scanner #(.PX_WIDTH(W), .PX_HEIGHT(H), .PIX_BITS(3), .ADDR_W(16),
                    .RD_LAT(LAT), .DECIM(DEC)) dut (
        .clk(clk), .clr(clr), .frame_tick(frame_tick), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_eol(out_eol),
        .out_eof(out_eof), .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0;
    int issued = 0, popped = 0, beats = 0;
    int rmode = 0, rph = 0;
    beat_t exp_q[$];
    logic [2:0] mem [16];
    logic [2:0] d1 = '0, d2 = '0;

    function automatic void chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, got, exp);
    endfunction

    // Pixel memory with LAT=2 cycles read latency; garbage on idle cycles.
    always @(posedge clk) begin
        d1 <= rd_en ? mem[rd_addr[3:0]] : 3'($urandom);
        d2 <= d1;
    end
    assign rd_data = d2;

    // Sink-side monitor: ordering, markers, hold-while-stalled, credit and addressing.
    beat_t held, e;
    logic  stall = 1'b0;
    always @(negedge clk) begin
        if (!clr) begin
            issued = 0;
            popped = 0;
            stall  = 1'b0;
        end else begin
            if (stall)
                chk("hold", 32'({out_valid, out_data, out_eol, out_eof}), 32'({1'b1, held}));
            if (rd_en) begin
                chk("credit", 32'((issued - popped) < DEPTH), 1);
                chk("rd_addr", 32'(rd_addr), issued % N);
                issued++;
            end
            if (out_valid && out_ready) begin
                chk("beat_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("beat", 32'({out_data, out_eol, out_eof}), 32'(e));
                end
                popped++;
                beats++;
            end
            stall = out_valid && !out_ready;
            held  = {out_data, out_eol, out_eof};
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (rph % 4 == 0) || (rph % 4 == 3);
                default: out_ready = ($urandom % 4) != 0;
            endcase
            rph++;
        end
    endtask

    task automatic load_frame(bit rnd);
        for (int i = 0; i < N; i++) begin
            mem[i] = rnd ? 3'($urandom) : 3'(i);
            exp_q.push_back(beat_t'({mem[i], (i % W) == W - 1, i == N - 1}));
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        frame_tick = 1'b0;
        exp_q.delete();
        step();
        clr = 1'b1;
        beats = 0;
    endtask

    task automatic wait_done(int fc);
        int k = 0;
        while (frame_cnt != 16'(fc) && k < 300) begin
            step();
            k++;
        end
        @(negedge clk);
        chk("frame_cnt", 32'(frame_cnt), fc);
        chk("idle_after", 32'(busy), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // reset with random inputs
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            frame_tick = 1'($urandom % 2);
            out_ready  = 1'($urandom % 2);
            @(negedge clk);
            chk("reset", 32'({rd_en, out_valid, busy, frame_cnt, drop_cnt}), 0);
        end
        @(posedge clk);
        #1;
        clr = 1'b1;
        frame_tick = 1'b0;

        // basic frame: data = addr[2:0], latency and full throughput
        rmode = 0;
        step(5);
        load_frame(0);
        tick();
        @(negedge clk);
        chk("first_rd", 32'({rd_en, rd_addr}), 32'({1'b1, 16'd0}));
        step();
        @(negedge clk);
        chk("valid_t2", 32'(out_valid), 0);
        step();
        @(negedge clk);
        chk("valid_t3", 32'(out_valid), 0);
        step();
        @(negedge clk);
        chk("valid_t4", 32'(out_valid), 1);
        step(12);
        chk("throughput_frame_cnt", 32'(frame_cnt), 1);
        chk("throughput_busy", 32'(busy), 0);
        chk("basic_beats", beats, N);

        // backpressure 1,0,0,1
        do_reset();
        rmode = 1;
        rph = 0;
        load_frame(1);
        tick();
        wait_done(1);
        chk("bp_beats", beats, N);

        // overrun: two extra triggers during the scan
        do_reset();
        rmode = 2;
        load_frame(1);
        tick();
        step(3);
        tick();
        step(4);
        tick();
        wait_done(1);
        step(20);
        chk("ovr_drop", 32'(drop_cnt), 2);
        chk("ovr_frames", 32'(frame_cnt), 1);
        chk("ovr_beats", beats, N);

        // decimation: only every DEC-th idle trigger starts a scan
        do_reset();
        rmode = 0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (acc % DEC == 0) load_frame(1);
            tick();
            @(negedge clk);
            chk("decim_busy", 32'(busy), 32'(acc % DEC == 0));
            acc++;
            step(39);
        end
        @(negedge clk);
        chk("decim_frames", 32'(frame_cnt), 2);
        chk("decim_drop", 32'(drop_cnt), 0);
        chk("decim_beats", beats, 2 * N);

        // mid-frame reset, then a clean restart
        do_reset();
        rmode = 0;
        load_frame(1);
        tick();
        for (int k = 0; k < 100 && beats < 6; k++) step();
        clr = 1'b0;
        exp_q.delete();
        step();
        clr = 1'b1;
        beats = 0;
        @(negedge clk);
        chk("midrst_state", 32'({out_valid, busy}), 0);
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge clk);
            chk("midrst_quiet", 32'({out_valid, busy, rd_en}), 0);
        end
        load_frame(1);
        tick();
        wait_done(1);
        chk("restart_beats", beats, N);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
